// File: rtl/vending_order_ctrl.sv
// ---------------------------------------------------------------------------
// vending_order_ctrl
// Customer front end of the beverage machine. It takes coin pulses, keeps
// the credit, charges the drink price on confirm, and hands the drink code to
// the preparation FSM, holding it until that FSM reports finish. Any credit
// left after an order, or refunded by cancel, is paid out one unit per
// change_pulse, CHANGE_GAP cycles apart.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active low
//   coin_1/5/10   one-cycle coin pulses worth 1, 5 and 10 units
//   sel_btn       drink code, 1..5 valid
//   confirm       one-cycle buy request for sel_btn
//   cancel        one-cycle refund request
//   finish        preparation FSM has completed the drink
//   seleccion     drink code presented to the preparation FSM
//   order_valid   order outstanding
//   credit        current credit for the display
//   change_pulse  one unit of change returned
//   coin_reject   coin returned without being credited
//   insufficient  confirm refused for lack of credit
//   busy          order or change payout in progress
//
// state  | meaning
// IDLE   | no credit, nothing in progress
// CREDIT | credit > 0, waiting for coins, confirm or cancel
// ORDER  | drink code held for the preparation FSM until finish
// CHANGE | paying out credit, one unit per change_pulse
// ---------------------------------------------------------------------------
module vending_order_ctrl #(
    parameter int W          = 8,
    parameter int CREDIT_MAX = 50,
    parameter int PRICE_1    = 10,
    parameter int PRICE_2    = 15,
    parameter int PRICE_3    = 15,
    parameter int PRICE_4    = 20,
    parameter int PRICE_5    = 5,
    parameter int CHANGE_GAP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         coin_1,
    input  logic         coin_5,
    input  logic         coin_10,
    input  logic [2:0]   sel_btn,
    input  logic         confirm,
    input  logic         cancel,
    input  logic         finish,
    output logic [2:0]   seleccion,
    output logic         order_valid,
    output logic [W-1:0] credit,
    output logic         change_pulse,
    output logic         coin_reject,
    output logic         insufficient,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, CREDIT, ORDER, CHANGE} state_t;

    localparam int GW = $clog2(CHANGE_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(CHANGE_GAP - 1);

    localparam logic [W-1:0] P1 = W'(PRICE_1);
    localparam logic [W-1:0] P2 = W'(PRICE_2);
    localparam logic [W-1:0] P3 = W'(PRICE_3);
    localparam logic [W-1:0] P4 = W'(PRICE_4);
    localparam logic [W-1:0] P5 = W'(PRICE_5);

    state_t          state;
    logic [GW-1:0]   gap_cnt;

    logic            coin_any;
    logic            coin_lose;
    logic            coin_fits;
    logic            coin_rej;
    logic [W-1:0]    coin_val;
    logic [W-1:0]    credit_acc;
    logic [W-1:0]    sel_price;
    logic            sel_valid;
    logic            can_buy;

    // Highest coin wins; lower-valued coins in the same cycle are losers.
    always_comb begin
        coin_val  = '0;
        coin_lose = 1'b0;
        if (coin_10) begin
            coin_val  = W'(10);
            coin_lose = coin_5 | coin_1;
        end else if (coin_5) begin
            coin_val  = W'(5);
            coin_lose = coin_1;
        end else if (coin_1) begin
            coin_val  = W'(1);
        end
        coin_any  = coin_1 | coin_5 | coin_10;
        coin_fits = ({1'b0, credit} + {1'b0, coin_val}) <= (W+1)'(CREDIT_MAX);
        coin_rej  = coin_lose | (coin_any & ~coin_fits);
        credit_acc = credit + (coin_fits ? coin_val : '0);
    end

    always_comb begin
        sel_valid = 1'b1;
        sel_price = '0;
        case (sel_btn)
            3'd1:    sel_price = P1;
            3'd2:    sel_price = P2;
            3'd3:    sel_price = P3;
            3'd4:    sel_price = P4;
            3'd5:    sel_price = P5;
            default: sel_valid = 1'b0;
        endcase
        // Confirm is judged on the credit before this cycle's coin lands.
        can_buy = credit >= sel_price;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            credit       <= '0;
            seleccion    <= '0;
            order_valid  <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            busy         <= 1'b0;
        end else begin
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    coin_reject <= coin_rej;
                    if (cancel && state == CREDIT) begin
                        // First change unit goes out on the entry edge.
                        change_pulse <= 1'b1;
                        credit       <= credit_acc - W'(1);
                        gap_cnt      <= GAP_LOAD;
                        if (credit_acc == W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= CHANGE;
                            busy  <= 1'b1;
                        end
                    end else if (confirm && !cancel && sel_valid && can_buy) begin
                        seleccion   <= sel_btn;
                        order_valid <= 1'b1;
                        credit      <= credit_acc - sel_price;
                        state       <= ORDER;
                        busy        <= 1'b1;
                    end else begin
                        insufficient <= confirm & ~cancel & sel_valid & ~can_buy;
                        credit       <= credit_acc;
                        state        <= (credit_acc != '0) ? CREDIT : IDLE;
                        busy         <= 1'b0;
                    end
                end
                ORDER: begin
                    coin_reject <= coin_any;
                    if (finish) begin
                        seleccion   <= '0;
                        order_valid <= 1'b0;
                        if (credit != '0) begin
                            change_pulse <= 1'b1;
                            credit       <= credit - W'(1);
                            gap_cnt      <= GAP_LOAD;
                            if (credit == W'(1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= CHANGE;
                                busy  <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_any;
                    if (gap_cnt == '0) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - W'(1);
                        gap_cnt      <= GAP_LOAD;
                        if (credit == W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_order_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vending_order_ctrl
// Directed scenarios followed by a random run. Every cycle the DUT outputs
// are compared with a transaction-level model that tracks credit, the
// outstanding order and the remaining refund with its pulse countdown.
// ---------------------------------------------------------------------------
module tb_vending_order_ctrl;

    localparam int W          = 8;
    localparam int CREDIT_MAX = 50;
    localparam int CHANGE_GAP = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         coin_1 = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0;
    logic [2:0]   sel_btn = 3'd0;
    logic         confirm = 1'b0, cancel = 1'b0, finish = 1'b0;
    logic [2:0]   seleccion;
    logic         order_valid;
    logic [W-1:0] credit;
    logic         change_pulse, coin_reject, insufficient, busy;

    vending_order_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
        .sel_btn(sel_btn), .confirm(confirm), .cancel(cancel), .finish(finish),
        .seleccion(seleccion), .order_valid(order_valid), .credit(credit),
        .change_pulse(change_pulse), .coin_reject(coin_reject),
        .insufficient(insufficient), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 = waiting for customer, 1 = order outstanding, 2 = paying change
    int m_credit = 0, m_mode = 0, m_sel = 0, m_wait = 0;
    int m_valid = 0;
    int e_pulse = 0, e_rej = 0, e_ins = 0;

    function automatic int price_of(input int code);
        case (code)
            1: return 10;
            2: return 15;
            3: return 15;
            4: return 20;
            5: return 5;
            default: return -1;
        endcase
    endfunction

    task automatic pay_one();
        e_pulse  = 1;
        m_credit = m_credit - 1;
        m_wait   = CHANGE_GAP;
        m_mode   = (m_credit > 0) ? 2 : 0;
    endtask

    task automatic model(input bit c1, c5, c10, input int sb, input bit cf, cn, fin, rs);
        int ncoins, v, p;
        e_pulse = 0; e_rej = 0; e_ins = 0;
        if (!rs) begin
            m_credit = 0; m_mode = 0; m_sel = 0; m_valid = 0; m_wait = 0;
            return;
        end
        ncoins = int'(c1) + int'(c5) + int'(c10);
        v = c10 ? 10 : (c5 ? 5 : (c1 ? 1 : 0));
        case (m_mode)
            0: begin
                if (ncoins > 1) e_rej = 1;
                if (v > 0 && m_credit + v > CREDIT_MAX) begin
                    e_rej = 1;
                    v = 0;
                end
                p = price_of(sb);
                if (cn && m_credit > 0) begin
                    m_credit = m_credit + v;
                    pay_one();
                end else if (cf && !cn && p >= 0) begin
                    if (m_credit >= p) begin
                        m_sel = sb; m_valid = 1; m_mode = 1;
                        m_credit = m_credit + v - p;
                    end else begin
                        e_ins = 1;
                        m_credit = m_credit + v;
                    end
                end else begin
                    m_credit = m_credit + v;
                end
            end
            1: begin
                e_rej = (ncoins > 0) ? 1 : 0;
                if (fin) begin
                    m_sel = 0; m_valid = 0;
                    if (m_credit > 0) pay_one();
                    else m_mode = 0;
                end
            end
            default: begin
                e_rej = (ncoins > 0) ? 1 : 0;
                m_wait = m_wait - 1;
                if (m_wait == 0) pay_one();
            end
        endcase
    endtask

    // ---------------- stimulus ----------------
    int  cyc_no = 0;
    bit  track = 0;
    int  pulse_cnt = 0, last_pulse = 0, spacing_bad = 0;

    task automatic cyc(input bit c1, c5, c10, input int sb, input bit cf, cn, fin, rs);
        @(negedge clk);
        coin_1 = c1; coin_5 = c5; coin_10 = c10;
        sel_btn = 3'(sb); confirm = cf; cancel = cn; finish = fin; rst = rs;
        model(c1, c5, c10, sb, cf, cn, fin, rs);
        @(posedge clk);
        #1;
        cyc_no++;
        chk("credit",       int'(credit),       m_credit);
        chk("seleccion",    int'(seleccion),    m_sel);
        chk("order_valid",  int'(order_valid),  m_valid);
        chk("busy",         int'(busy),         (m_mode != 0) ? 1 : 0);
        chk("change_pulse", int'(change_pulse), e_pulse);
        chk("coin_reject",  int'(coin_reject),  e_rej);
        chk("insufficient", int'(insufficient), e_ins);
        if (track && change_pulse) begin
            if (pulse_cnt > 0 && cyc_no - last_pulse != CHANGE_GAP) spacing_bad++;
            pulse_cnt++;
            last_pulse = cyc_no;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic coin(input int val);
        cyc(val == 1, val == 5, val == 10, 0, 0, 0, 0, 1);
    endtask
    task automatic buy(input int code);
        cyc(0, 0, 0, code, 1, 0, 0, 1);
    endtask
    task automatic fin1();
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        // S1: exact-price purchase, no change
        do_reset(); do_reset();
        idle(1);
        coin(10); coin(5);
        buy(2);
        idle(2);
        fin1();
        idle(3);

        // S2: long order then 10 units of change at fixed spacing
        coin(10); coin(10);
        buy(1);
        idle(30);
        track = 1;
        fin1();
        idle(60);
        track = 0;
        chk("s2_pulses", pulse_cnt, 10);
        chk("s2_spacing_bad", spacing_bad, 0);

        // S3: insufficient credit, then invalid code
        do_reset();
        coin(5);
        buy(4);
        idle(1);
        buy(7);
        idle(2);

        // S4: overflow reject, then simultaneous coins at zero credit
        for (int i = 0; i < 4; i++) coin(10);
        coin(5);
        coin(10);
        idle(1);
        do_reset();
        cyc(1, 0, 1, 0, 0, 0, 0, 1);
        idle(1);

        // S5: cancel beats confirm, coin during change is rejected
        do_reset();
        coin(5); coin(1); coin(1);
        cyc(0, 0, 0, 5, 1, 1, 0, 1);
        idle(2);
        coin(5);
        idle(40);

        // S6: reset in ORDER and mid-CHANGE, then normal use
        coin(10);
        buy(1);
        idle(3);
        do_reset();
        idle(1);
        coin(10); coin(10);
        buy(5);
        fin1();
        idle(10);
        do_reset();
        idle(1);
        coin(10);
        buy(1);
        idle(2);
        fin1();
        idle(3);

        // Random run
        for (int i = 0; i < 4000; i++) begin
            bit c1, c5, c10, cf, cn, fin, rs;
            c1  = ($urandom_range(0, 5) == 0);
            c5  = ($urandom_range(0, 5) == 0);
            c10 = ($urandom_range(0, 5) == 0);
            cf  = ($urandom_range(0, 6) == 0);
            cn  = ($urandom_range(0, 25) == 0);
            fin = ($urandom_range(0, 4) == 0);
            rs  = ($urandom_range(0, 400) != 0);
            cyc(c1, c5, c10, int'($urandom_range(0, 7)), cf, cn, fin, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_order_ctrl.md
Name: vending_order_ctrl

Overview:
- Customer-facing front end of the beverage machine and the initiator side of the drink-preparation handshake.
- Accepts coin pulses and drink buttons, tracks credit, and charges the drink price.
- Issues the drink code to the preparation FSM and holds it until that FSM returns `finish`, then dispenses change one unit at a time.
- Sits between the button/coin input logic and the preparation controller.

Parameters:
- W, 8, credit register width (units).
- CREDIT_MAX, 50, maximum credit; must be ≤ 2^W-1.
- PRICE_1, 10, price of drink code 1.
- PRICE_2, 15, price of drink code 2.
- PRICE_3, 15, price of drink code 3.
- PRICE_4, 20, price of drink code 4.
- PRICE_5, 5, price of drink code 5.
- CHANGE_GAP, 4, clock cycles between change pulses; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- coin_1  in  1  one-cycle pulse, coin worth 1 unit.
- coin_5  in  1  one-cycle pulse, coin worth 5 units.
- coin_10  in  1  one-cycle pulse, coin worth 10 units.
- sel_btn  in  3  drink code; 1..5 valid, 0/6/7 invalid.
- confirm  in  1  one-cycle pulse, buy drink on sel_btn.
- cancel  in  1  one-cycle pulse, refund credit.
- finish  in  1  high when the preparation FSM has completed the drink.
- seleccion  out  3  drink code presented to the preparation FSM.
- order_valid  out  1  high while an order is outstanding.
- credit  out  W  current credit, for the display.
- change_pulse  out  1  one-cycle pulse; each pulse returns 1 unit.
- coin_reject  out  1  one-cycle pulse, coin returned uncredited.
- insufficient  out  1  one-cycle pulse, confirm refused for lack of credit.
- busy  out  1  high in ORDER or CHANGE.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge, any state, including mid-order or mid-change):
  - state IDLE, credit=0.
  - seleccion=0, order_valid=0, change_pulse=0, coin_reject=0, insufficient=0, busy=0.
- States: IDLE, CREDIT, ORDER, CHANGE.
  - IDLE ⇔ credit==0 and no order or change in progress.
  - CREDIT ⇔ credit>0 and not busy.
- Coin handling (IDLE/CREDIT only):
  - Several coin pulses in one cycle: the highest value is taken (10 > 5 > 1); the others are rejected.
  - Value accepted only if credit+value ≤ CREDIT_MAX; credit updates on the next edge.
  - A rejected coin (overflow, simultaneous loser, or any coin in ORDER/CHANGE) sets coin_reject=1 for exactly one cycle.
  - A coin accepted from IDLE moves the FSM to CREDIT.
- Confirm (IDLE/CREDIT):
  - sel_btn invalid: no effect.
  - Valid code and credit ≥ PRICE_n, next edge:
    - seleccion←sel_btn, credit←credit-PRICE_n, order_valid←1, state ORDER.
    - A price of 0 from IDLE is allowed.
  - Valid code and credit < PRICE_n: insufficient=1 for one cycle; credit and state unchanged.
- Coin and confirm in the same cycle: the coin is processed first, and its credit does not count toward this confirm (confirm uses the pre-edge credit).
- Cancel (CREDIT): go to CHANGE. Cancel in IDLE: no effect. Cancel and confirm together: cancel wins; confirm is ignored.
- ORDER:
  - seleccion and order_valid held stable; confirm and cancel ignored; coins rejected.
  - On the first edge with finish=1: seleccion←0, order_valid←0.
  - Then go to CHANGE if credit>0, else IDLE.
  - `finish` is only sampled in ORDER.
- CHANGE:
  - Internal gap counter. change_pulse=1 for one cycle, starting on the first cycle in CHANGE, then every CHANGE_GAP cycles.
  - Each pulse decrements credit by 1 on the same edge.
  - When the decrement makes credit 0: go to IDLE, with no further pulse.
  - Total pulses equal the credit at entry to CHANGE. confirm and cancel ignored; coins rejected.
- busy=1 exactly when state is ORDER or CHANGE.
- Arithmetic is unsigned W-bit; credit never wraps (guaranteed by the CREDIT_MAX and price checks).

Test Plan:
1. Reset then coin_10, coin_5 → credit 10 then 15; confirm sel_btn=2 → next cycle order_valid=1, seleccion=2, credit=0, busy=1; finish high 1 cycle → order_valid=0, seleccion=0, IDLE, no change_pulse.
2. credit=20, confirm sel_btn=1, finish after 30 cycles → seleccion held at 1 throughout; then 10 change_pulses spaced 4 cycles apart; credit counts 10→0; busy drops with the last pulse.
3. credit=5, confirm sel_btn=4 → insufficient pulse for 1 cycle, credit stays 5; confirm sel_btn=7 → no response.
4. credit=45, coin_10 → coin_reject pulse, credit stays 45; coin_10+coin_1 together at credit=0 → credit=10, coin_reject=1.
5. credit=7, cancel and confirm(sel 5) in the same cycle → CHANGE with 7 pulses, no order; coin_5 during CHANGE → coin_reject, credit unaffected.
6. rst=0 asserted in ORDER and again midway through CHANGE → all outputs 0 and credit 0 on the next edge; normal purchase works afterwards.
